// File: rtl/cronometro_pkg.sv
// Shared definitions for the stopwatch run/pause/clear sequencer.
// Optional lap feature is enabled by defining CRONOMETRO_LAP_EN.
package cronometro_pkg;

  // Sequencer states, 2-bit encoding; CLEAR is the reset state.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  // Depth of every switch synchronizer.
  localparam int SYNC_STAGES = 2;

  // True in the states where the lap switch is allowed to toggle the hold.
  function automatic logic lap_allowed(input state_e st);
    return (st == ST_RUN) || (st == ST_PAUSE);
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Multi-flop synchronizer for an asynchronous board switch.
// Synchronous active-high reset clears every stage to 0.
module sincronizador
  import cronometro_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw switch level one stage further each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_i};
  end

  // Synchronizer stages, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/cronometro_ctrl.sv
// Run/pause/clear sequencer for the chained stopwatch digit counters.
// Synchronizes the switches, divides the clock into a one-cycle seconds
// tick, drives tick/clear into the first digit and watches the wrap carry.
// Define CRONOMETRO_LAP_EN to add the SW15 lap switch and lap_hold output.
module cronometro_ctrl
  import cronometro_pkg::*;
#(
  parameter int TICK_DIV     = 50000000,
  parameter int CNT_W        = 26,
  parameter int STOP_ON_WRAP = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic SW16,
  input  logic SW17,
`ifdef CRONOMETRO_LAP_EN
  input  logic SW15,
  output logic lap_hold,
`endif
  input  logic wrap_in,
  output logic tick_en,
  output logic clr,
  output logic running,
  output logic halted
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             STOP_EN  = (STOP_ON_WRAP != 0);

  logic s16;
  logic s17;

  state_e state_q;
  state_e state_d;

  logic [CNT_W-1:0] pres_q;
  logic [CNT_W-1:0] pres_d;
  logic             tick_q;
  logic             tick_d;
  logic             clr_q;
  logic             clr_d;
  logic             running_q;
  logic             running_d;
  logic             halted_q;
  logic             halted_d;

  sincronizador #(.STAGES(SYNC_STAGES)) u_sync_sw16 (
    .clock   (clock),
    .reset   (reset),
    .async_i (SW16),
    .sync_o  (s16)
  );

  sincronizador #(.STAGES(SYNC_STAGES)) u_sync_sw17 (
    .clock   (clock),
    .reset   (reset),
    .async_i (SW17),
    .sync_o  (s17)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; the clear switch always wins, the wrap stop beats pause.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: begin
        if (s17) begin
          state_d = ST_CLEAR;
        end else if (s16) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (s17) begin
          state_d = ST_CLEAR;
        end else if (STOP_EN && wrap_in) begin
          state_d = ST_HALT;
        end else if (s16) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (s17) begin
          state_d = ST_CLEAR;
        end else if (!s16) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_HALT: begin
        if (s17) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Prescaler and tick; the tick depends only on the current state, so a
  // second that completes on the same edge as a pause/clear still counts.
  // Pause and halt hold the count so a partial second survives a pause.
  always_comb begin
    pres_d = pres_q;
    tick_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (pres_q == CNT_TERM) begin
          pres_d = '0;
          tick_d = 1'b1;
        end else begin
          pres_d = pres_q + CNT_ONE;
          tick_d = 1'b0;
        end
      end
      ST_PAUSE, ST_HALT: begin
        pres_d = pres_q;
      end
      ST_CLEAR: begin
        pres_d = '0;
      end
      default: begin
        pres_d = '0;
      end
    endcase
  end

  // Status outputs decoded from the next state so they line up with state_q.
  always_comb begin
    clr_d     = (state_d == ST_CLEAR);
    running_d = (state_d == ST_RUN);
    halted_d  = (state_d == ST_HALT);
  end

  // Prescaler and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      pres_q    <= '0;
      tick_q    <= 1'b0;
      clr_q     <= 1'b1;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      pres_q    <= pres_d;
      tick_q    <= tick_d;
      clr_q     <= clr_d;
      running_q <= running_d;
      halted_q  <= halted_d;
    end
  end

  assign tick_en = tick_q;
  assign clr     = clr_q;
  assign running = running_q;
  assign halted  = halted_q;

`ifdef CRONOMETRO_LAP_EN
  logic s15;
  logic s15_prev_q;
  logic lap_q;
  logic lap_d;

  sincronizador #(.STAGES(SYNC_STAGES)) u_sync_sw15 (
    .clock   (clock),
    .reset   (reset),
    .async_i (SW15),
    .sync_o  (s15)
  );

  // Lap hold: cleared with the digits, toggled by a lap switch press while
  // counting or paused, otherwise held (including in HALT).
  always_comb begin
    if (state_d == ST_CLEAR) begin
      lap_d = 1'b0;
    end else if (lap_allowed(state_q) && s15 && !s15_prev_q) begin
      lap_d = !lap_q;
    end else begin
      lap_d = lap_q;
    end
  end

  // Lap edge detector and hold register.
  always_ff @(posedge clock) begin
    if (reset) begin
      s15_prev_q <= 1'b0;
      lap_q      <= 1'b0;
    end else begin
      s15_prev_q <= s15;
      lap_q      <= lap_d;
    end
  end

  assign lap_hold = lap_q;
`endif

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Directed bench for cronometro_ctrl with TICK_DIV=4: one instance that
// halts on wrap (u1) and one that free-runs through wrap (u0).
module tb_cronometro_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic sw16;
  logic sw17;
  logic wrap_in;
  logic tick0, clr0, run0, halt0;
  logic tick1, clr1, run1, halt1;
`ifdef CRONOMETRO_LAP_EN
  logic sw15;
  logic lap0, lap1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  cronometro_ctrl #(.TICK_DIV(4), .CNT_W(3), .STOP_ON_WRAP(0)) u0 (
    .clock    (clock),
    .reset    (reset),
    .SW16     (sw16),
    .SW17     (sw17),
`ifdef CRONOMETRO_LAP_EN
    .SW15     (sw15),
    .lap_hold (lap0),
`endif
    .wrap_in  (wrap_in),
    .tick_en  (tick0),
    .clr      (clr0),
    .running  (run0),
    .halted   (halt0)
  );

  cronometro_ctrl #(.TICK_DIV(4), .CNT_W(3), .STOP_ON_WRAP(1)) u1 (
    .clock    (clock),
    .reset    (reset),
    .SW16     (sw16),
    .SW17     (sw17),
`ifdef CRONOMETRO_LAP_EN
    .SW15     (sw15),
    .lap_hold (lap1),
`endif
    .wrap_in  (wrap_in),
    .tick_en  (tick1),
    .clr      (clr1),
    .running  (run1),
    .halted   (halt1)
  );

  // One per-cycle vector: inputs, then expected {tick,clr,run,halt} of u1
  // and running of u0 (u0 never halts).
  typedef struct {
    logic       s16;
    logic       s17;
    logic       wr;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s16, input logic s17, input logic wr,
                     input logic [4:0] exp, input int n);
    vec_t v;
    v.s16 = s16;
    v.s17 = s17;
    v.wr  = wr;
    v.exp = exp;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Safety net against a hung simulation.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int ticks;
    reset   = 1'b1;
    sw16    = 1'b0;
    sw17    = 1'b0;
    wrap_in = 1'b0;
`ifdef CRONOMETRO_LAP_EN
    sw15    = 1'b0;
`endif
    step();
    step();
    check("reset_state", {tick1, clr1, run1, halt1, tick0, clr0, run0, halt0}, 8'b0100_0100);
`ifdef CRONOMETRO_LAP_EN
    check("reset_lap", {7'd0, lap1}, 8'd0);
`endif

    // Codes: 00101 run, 10101 tick, 00000 paused, 01000 clear,
    //        11000 tick+clear, 00011 u1 halted/u0 run, 00010 u1 halted/u0 paused.
    add(1'b0, 1'b0, 1'b0, 5'b00101, 4);  // rows 1-4: RUN on first edge
    add(1'b0, 1'b0, 1'b0, 5'b10101, 1);  // row 5: first tick, 4 cycles in
    add(1'b0, 1'b0, 1'b0, 5'b00101, 3);
    add(1'b0, 1'b0, 1'b0, 5'b10101, 1);  // row 9: period 4
    add(1'b0, 1'b0, 1'b0, 5'b00101, 2);  // prescaler at 2
    add(1'b1, 1'b0, 1'b0, 5'b00101, 1);  // raise SW16
    add(1'b1, 1'b0, 1'b0, 5'b10101, 1);
    add(1'b1, 1'b0, 1'b0, 5'b00000, 1);  // row 14: PAUSE, prescaler at 1
    add(1'b0, 1'b0, 1'b0, 5'b00000, 2);  // drop SW16, sync latency
    add(1'b0, 1'b0, 1'b0, 5'b00101, 3);  // row 17: resume
    add(1'b0, 1'b0, 1'b0, 5'b10101, 1);  // row 20: partial second kept
    add(1'b0, 1'b0, 1'b0, 5'b00101, 1);
    add(1'b1, 1'b1, 1'b0, 5'b00101, 2);  // both switches
    add(1'b1, 1'b1, 1'b0, 5'b11000, 1);  // row 24: tick and CLEAR together
    add(1'b1, 1'b1, 1'b0, 5'b01000, 2);  // held clear: no ticks
    add(1'b0, 1'b0, 1'b0, 5'b01000, 2);
    add(1'b0, 1'b0, 1'b0, 5'b00101, 4);  // row 29: RUN from prescaler 0
    add(1'b0, 1'b0, 1'b0, 5'b10101, 1);  // row 33
    add(1'b0, 1'b0, 1'b1, 5'b00011, 1);  // row 34: wrap -> u1 HALT
    add(1'b1, 1'b0, 1'b0, 5'b00011, 2);  // SW16 toggle
    add(1'b0, 1'b0, 1'b0, 5'b00010, 2);
    add(1'b0, 1'b0, 1'b1, 5'b00011, 1);  // wrap in HALT ignored
    add(1'b0, 1'b1, 1'b0, 5'b00011, 2);
    add(1'b0, 1'b1, 1'b0, 5'b01000, 1);  // row 42: HALT -> CLEAR
    add(1'b0, 1'b0, 1'b0, 5'b01000, 2);
    add(1'b0, 1'b0, 1'b0, 5'b00101, 1);  // row 45

    reset = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      sw16    = tbl[i].s16;
      sw17    = tbl[i].s17;
      wrap_in = tbl[i].wr;
      step();
      check($sformatf("row%0d", i + 1),
            {2'b00, tick1, clr1, run1, halt1, run0, halt0},
            {2'b00, tbl[i].exp, 1'b0});
    end
    sw16    = 1'b0;
    sw17    = 1'b0;
    wrap_in = 1'b0;

`ifdef CRONOMETRO_LAP_EN
    // Lap presses in RUN; ticks keep coming every 4 cycles.
    ticks = 0;
    for (int s = 1; s <= 19; s++) begin
      sw15 = ((s >= 1 && s <= 3) || (s >= 7 && s <= 9) || s >= 13) ? 1'b1 : 1'b0;
      sw17 = (s >= 17) ? 1'b1 : 1'b0;
      step();
      if (s <= 16 && tick1 === 1'b1) ticks++;
      if (s == 3)  check("lap_on",      {6'd0, lap1, lap0}, 8'b11);
      if (s == 9)  check("lap_off",     {6'd0, lap1, lap0}, 8'b00);
      if (s == 15) check("lap_on2",     {6'd0, lap1, lap0}, 8'b11);
      if (s == 16) check("lap_ticks",   8'(ticks), 8'd4);
      if (s == 18) check("lap_hold_pre", {6'd0, lap1, lap0}, 8'b11);
      if (s == 19) check("lap_clear",   {6'd0, lap1, lap0}, 8'b00);
    end
    sw15 = 1'b0;
    sw17 = 1'b0;
`else
    ticks = 0;
`endif

    // Reset mid-count with SW16 high still lands in CLEAR.
    for (int s = 0; s < 6; s++) begin
      step();
      if (tick1 === 1'b1) ticks++;
    end
    sw16  = 1'b1;
    reset = 1'b1;
    step();
    check("midreset", {tick1, clr1, run1, halt1, tick0, clr0, run0, halt0}, 8'b0100_0100);
    sw16  = 1'b0;
    reset = 1'b0;
    step();
    check("after_reset", {tick1, clr1, run1, halt1, tick0, clr0, run0, halt0}, 8'b0010_0010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
